// File: rtl/pipelined_compare_if.sv
// ----------------------------------------------------------------------------
// pipelined_compare_if
// Handshake bundle for the pipelined comparator.
//   Input side : i_valid / i_ready, operands i0 and i1, relation code op
//   Output side: o_valid / o_ready, one-bit result o
// Modports:
//   master - the producer/consumer environment around the comparator
//   slave  - the comparator itself
// ----------------------------------------------------------------------------
interface pipelined_compare_if #(
    parameter int WIDTH = 32
) ();
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [2:0]       op;
    logic             o_valid;
    logic             o_ready;
    logic             o;

    modport master (
        output i_valid, i0, i1, op, o_ready,
        input  i_ready, o_valid, o
    );

    modport slave (
        input  i_valid, i0, i1, op, o_ready,
        output i_ready, o_valid, o
    );
endinterface

// File: rtl/pipelined_compare.sv
// ----------------------------------------------------------------------------
// pipelined_compare
// Streaming WIDTH-bit comparator with a runtime relation select
// (0 EQ, 1 NE, 2 ULT, 3 ULE, 4 UGT, 5 UGE, 6 SLT, 7 SLE; A rel B).
// The relation is resolved LSB-first, SEG_W bits per pipeline stage, so the
// result appears NSTAGE = ceil(WIDTH/SEG_W) cycles after acceptance.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   bus        pipelined_compare_if.slave (i_valid/i_ready/i0/i1/op in,
//              o_valid/o_ready/o out)
//   cnt_clr    synchronous clear of match_cnt (optional)
//   match_cnt  saturating count of true results transferred (optional)
//
// Optional feature: define PIPELINED_COMPARE_COUNT_EN to add the match
// counter and its cnt_clr / match_cnt ports.
// ----------------------------------------------------------------------------
module pipelined_compare #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_compare_if.slave    bus
`ifdef PIPELINED_COMPARE_COUNT_EN
    ,
    input  logic                  cnt_clr,
    output logic [15:0]           match_cnt
`endif
);

    localparam int NSTAGE = (WIDTH + SEG_W - 1) / SEG_W;
    localparam int PW     = NSTAGE * SEG_W;
    localparam int RN     = (NSTAGE > 1) ? NSTAGE - 1 : 1;

    typedef enum logic [1:0] {
        CLS_EQ,
        CLS_NE,
        CLS_LT,
        CLS_LE
    } cls_t;

    logic adv;

    // Whole pipeline moves as one; no bubble collapsing.
    assign adv         = !bus.o_valid || bus.o_ready;
    assign bus.i_ready = adv;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sgn;
    cls_t             in_cls;
    logic             in_p;
    logic [PW-1:0]    pad_a;
    logic [PW-1:0]    pad_b;

    // Greater-than relations become less-than with swapped operands. Signed
    // relations flip the padded MSB so that an unsigned chain orders them.
    always_comb begin
        op_a   = bus.i0;
        op_b   = bus.i1;
        sgn    = 1'b0;
        in_cls = CLS_EQ;
        case (bus.op)
            3'd0: in_cls = CLS_EQ;
            3'd1: in_cls = CLS_NE;
            3'd2: in_cls = CLS_LT;
            3'd3: in_cls = CLS_LE;
            3'd4: begin
                in_cls = CLS_LT;
                op_a   = bus.i1;
                op_b   = bus.i0;
            end
            3'd5: begin
                in_cls = CLS_LE;
                op_a   = bus.i1;
                op_b   = bus.i0;
            end
            3'd6: begin
                in_cls = CLS_LT;
                sgn    = 1'b1;
            end
            default: begin
                in_cls = CLS_LE;
                sgn    = 1'b1;
            end
        endcase

        pad_a = PW'(op_a);
        pad_b = PW'(op_b);
        if (sgn) begin
            for (int i = WIDTH; i < PW; i++) begin
                pad_a[i] = op_a[WIDTH-1];
                pad_b[i] = op_b[WIDTH-1];
            end
        end
        pad_a[PW-1] = pad_a[PW-1] ^ sgn;
        pad_b[PW-1] = pad_b[PW-1] ^ sgn;

        // LT starts "not less" so full equality yields 0; EQ/NE/LE start at 1.
        in_p = (in_cls != CLS_LT);
    end

    logic [PW-1:0] cur_a   [NSTAGE];
    logic [PW-1:0] cur_b   [NSTAGE];
    cls_t          cur_cls [NSTAGE];
    logic          cur_p   [NSTAGE];
    logic          cur_v   [NSTAGE];
    logic [PW-1:0] nxt_a   [NSTAGE];
    logic [PW-1:0] nxt_b   [NSTAGE];
    cls_t          nxt_cls [NSTAGE];
    logic          nxt_p   [NSTAGE];
    logic          nxt_v   [NSTAGE];

    logic [PW-1:0] r_a     [RN];
    logic [PW-1:0] r_b     [RN];
    cls_t          r_cls   [RN];
    logic          r_p     [RN];
    logic          r_v     [RN];

    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic             seg_eq;
    logic             seg_lt;

    // Operands shift right one segment per stage, so every stage looks at
    // the low SEG_W bits. The partial bit carries the verdict of all lower
    // segments; a higher segment overrides it unless that segment is equal.
    always_comb begin
        seg_a  = '0;
        seg_b  = '0;
        seg_eq = 1'b0;
        seg_lt = 1'b0;

        cur_a[0]   = pad_a;
        cur_b[0]   = pad_b;
        cur_cls[0] = in_cls;
        cur_p[0]   = in_p;
        cur_v[0]   = bus.i_valid;
        for (int s = 1; s < NSTAGE; s++) begin
            cur_a[s]   = r_a[s-1];
            cur_b[s]   = r_b[s-1];
            cur_cls[s] = r_cls[s-1];
            cur_p[s]   = r_p[s-1];
            cur_v[s]   = r_v[s-1];
        end

        for (int s = 0; s < NSTAGE; s++) begin
            seg_a      = cur_a[s][SEG_W-1:0];
            seg_b      = cur_b[s][SEG_W-1:0];
            seg_eq     = (seg_a == seg_b);
            seg_lt     = (seg_a < seg_b);
            nxt_a[s]   = cur_a[s] >> SEG_W;
            nxt_b[s]   = cur_b[s] >> SEG_W;
            nxt_cls[s] = cur_cls[s];
            nxt_v[s]   = cur_v[s];
            if (cur_cls[s] == CLS_EQ || cur_cls[s] == CLS_NE) begin
                nxt_p[s] = cur_p[s] & seg_eq;
            end else begin
                nxt_p[s] = seg_lt | (seg_eq & cur_p[s]);
            end
        end
    end

    // The last stage writes straight into the output register, which keeps
    // the latency at exactly NSTAGE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSTAGE - 1; s++) begin
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_cls[s] <= CLS_EQ;
                r_p[s]   <= 1'b0;
                r_v[s]   <= 1'b0;
            end
            bus.o_valid <= 1'b0;
            bus.o       <= 1'b0;
        end else if (adv) begin
            for (int s = 0; s < NSTAGE - 1; s++) begin
                r_a[s]   <= nxt_a[s];
                r_b[s]   <= nxt_b[s];
                r_cls[s] <= nxt_cls[s];
                r_p[s]   <= nxt_p[s];
                r_v[s]   <= nxt_v[s];
            end
            bus.o_valid <= nxt_v[NSTAGE-1];
            bus.o       <= (nxt_cls[NSTAGE-1] == CLS_NE) ? !nxt_p[NSTAGE-1]
                                                         : nxt_p[NSTAGE-1];
        end
    end

`ifdef PIPELINED_COMPARE_COUNT_EN
    // Clear takes priority over a coincident counted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (bus.o_valid && bus.o_ready && bus.o && match_cnt != 16'hFFFF) begin
            match_cnt <= match_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_compare.sv
// ----------------------------------------------------------------------------
// tb_pipelined_compare
// Directed bench for pipelined_compare: a 32/8 instance for the main
// scenarios and a 13/4 instance checked against a behavioural model.
// Define PIPELINED_COMPARE_COUNT_EN to also exercise the match counter.
// ----------------------------------------------------------------------------
module tb_pipelined_compare;

    localparam int NSTAGE = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pipelined_compare_if #(.WIDTH(32)) bus ();
    pipelined_compare_if #(.WIDTH(13)) bus13 ();

`ifdef PIPELINED_COMPARE_COUNT_EN
    logic        cnt_clr;
    logic [15:0] match_cnt;
    logic [15:0] match_cnt13;
`endif

    pipelined_compare #(.WIDTH(32), .SEG_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PIPELINED_COMPARE_COUNT_EN
        .cnt_clr   (cnt_clr),
        .match_cnt (match_cnt),
`endif
        .bus       (bus)
    );

    pipelined_compare #(.WIDTH(13), .SEG_W(4)) dut13 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PIPELINED_COMPARE_COUNT_EN
        .cnt_clr   (1'b0),
        .match_cnt (match_cnt13),
`endif
        .bus       (bus13)
    );

    always #5 clk = ~clk;

    function automatic logic model13(input logic [12:0] a, input logic [12:0] b,
                                     input logic [2:0] op);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return a < b;
            3'd3: return a <= b;
            3'd4: return a > b;
            3'd5: return a >= b;
            3'd6: return $signed(a) < $signed(b);
            default: return $signed(a) <= $signed(b);
        endcase
    endfunction

    task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, output logic res, output bit seen);
        res  = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        bus.i0      = a;
        bus.i1      = b;
        bus.op      = op;
        bus.i_valid = 1'b1;
        bus.o_ready = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            if (bus.o_valid) begin
                res  = bus.o;
                seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_o_valid: got %b expected 0", bus.o_valid);
        end
        checks++;
        if (bus.o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_o: got %b expected 0", bus.o);
        end
        checks++;
        if (bus.i_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_i_ready: got %b expected 1", bus.i_ready);
        end
        checks++;
        if (bus13.o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_o_valid13: got %b expected 0", bus13.o_valid);
        end
`ifdef PIPELINED_COMPARE_COUNT_EN
        checks++;
        if (match_cnt !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_match_cnt: got %h expected 0000", match_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_o_valid: got %b expected 0", bus.o_valid);
        end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        bus.i0      = 32'd5;
        bus.i1      = 32'd5;
        bus.op      = 3'd0;
        bus.i_valid = 1'b1;
        bus.o_ready = 1'b1;
        #1;
        checks++;
        if (bus.i_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency_i_ready: got %b expected 1", bus.i_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            checks++;
            if (bus.o_valid !== (k == NSTAGE)) begin
                errors++;
                $display("[TB] FAIL latency_o_valid_cycle%0d: got %b expected %b",
                         k, bus.o_valid, (k == NSTAGE));
            end
            if (k == NSTAGE) begin
                checks++;
                if (bus.o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL latency_o: got %b expected 1", bus.o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits = 8'b1111_0010;
        int sent  = 0;
        int got   = 0;
        int first = -1;
        int last  = -1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(posedge clk); #1;
            bus.o_ready = 1'b1;
            if (sent < 8) begin
                bus.i0      = 32'hFFFF_FFFF;
                bus.i1      = 32'h0000_0001;
                bus.op      = 3'(sent);
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (bus.o_valid && bus.o_ready) begin
                checks++;
                if (bus.o !== exp_bits[got]) begin
                    errors++;
                    $display("[TB] FAIL b2b_op%0d: got %b expected %b", got, bus.o, exp_bits[got]);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (bus.i_valid && bus.i_ready) sent++;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (got != 8) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d results expected 8", got);
        end
        checks++;
        if (last - first != 7) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got span %0d expected 7", last - first);
        end
    endtask

    task automatic test_carry();
        logic [31:0] va [10] = '{32'h0100_0000, 32'h8000_0000, 32'h00FF_FFFF, 32'h7FFF_FFFF,
                                 32'h7FFF_FFFF, 32'h1234_5678, 32'h1234_5678, 32'h0000_00FF,
                                 32'h8000_0001, 32'hFFFF_FF00};
        logic [31:0] vb [10] = '{32'h00FF_FFFF, 32'h00FF_FFFF, 32'h0100_0000, 32'h8000_0000,
                                 32'h8000_0000, 32'h9234_5678, 32'h9234_5678, 32'h0000_0100,
                                 32'h8000_0001, 32'hFFFF_FFFF};
        logic [2:0]  vo [10] = '{3'd2, 3'd7, 3'd2, 3'd6, 3'd2, 3'd0, 3'd1, 3'd5, 3'd7, 3'd6};
        logic        ve [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic res;
        bit   seen;
        for (int i = 0; i < 10; i++) begin
            send_one(va[i], vb[i], vo[i], res, seen);
            checks++;
            if (!seen || res !== ve[i]) begin
                errors++;
                $display("[TB] FAIL carry_%0d: got %b (seen %0d) expected %b", i, res, seen, ve[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] va [6] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd7, 32'd8};
        logic [31:0] vb [6] = '{32'd2, 32'd1, 32'd3, 32'd4, 32'd7, 32'd7};
        logic [2:0]  vo [6] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd1, 3'd4};
        logic        ve [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            bus.o_ready = 1'b0;
            if (sent < 6) begin
                bus.i0 = va[sent]; bus.i1 = vb[sent]; bus.op = vo[sent];
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (cyc >= 5) begin
                checks++;
                if (bus.o_valid !== 1'b1 || bus.i_ready !== 1'b0 || bus.o !== ve[0]) begin
                    errors++;
                    $display("[TB] FAIL stall_hold_cycle%0d: got o_valid=%b i_ready=%b o=%b expected 1 0 %b",
                             cyc, bus.o_valid, bus.i_ready, bus.o, ve[0]);
                end
            end
            if (bus.i_valid && bus.i_ready) sent++;
        end
        checks++;
        if (sent != NSTAGE) begin
            errors++;
            $display("[TB] FAIL stall_accepted: got %0d expected %0d", sent, NSTAGE);
        end
        for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
            @(posedge clk); #1;
            bus.o_ready = 1'b1;
            if (sent < 6) begin
                bus.i0 = va[sent]; bus.i1 = vb[sent]; bus.op = vo[sent];
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (bus.o_valid && bus.o_ready) begin
                checks++;
                if (bus.o !== ve[got]) begin
                    errors++;
                    $display("[TB] FAIL stall_drain_%0d: got %b expected %b", got, bus.o, ve[got]);
                end
                got++;
            end
            if (bus.i_valid && bus.i_ready) sent++;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (got != 6) begin
            errors++;
            $display("[TB] FAIL stall_emitted: got %0d expected 6", got);
        end
    endtask

    task automatic test_reset_midstream();
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk); #1;
            bus.o_ready = 1'b1;
            bus.i0 = 32'd9; bus.i1 = 32'd9; bus.op = 3'd0;
            bus.i_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_pre_o_valid: got %b expected 1", bus.o_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got o_valid=%b o=%b expected 0 0", bus.o_valid, bus.o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.o_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_stale_cycle%0d: got o_valid=%b expected 0", cyc, bus.o_valid);
            end
        end
    endtask

    task automatic test_narrow_random();
        logic        exp_q [$];
        logic        exp;
        logic [12:0] a;
        logic [12:0] b;
        logic [2:0]  op;
        int sent = 0;
        int got  = 0;
        a  = 13'($urandom);
        b  = 13'($urandom);
        op = 3'($urandom_range(0, 7));
        for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
            @(posedge clk); #1;
            bus13.o_ready = ($urandom_range(0, 3) != 0);
            bus13.i_valid = (sent < 40);
            bus13.i0 = a; bus13.i1 = b; bus13.op = op;
            #1;
            if (bus13.o_valid && bus13.o_ready) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                checks++;
                if (bus13.o !== exp) begin
                    errors++;
                    $display("[TB] FAIL narrow_%0d: got %b expected %b", got, bus13.o, exp);
                end
                got++;
            end
            if (bus13.i_valid && bus13.i_ready) begin
                exp_q.push_back(model13(a, b, op));
                sent++;
                a  = 13'($urandom);
                b  = ($urandom_range(0, 3) == 0) ? a : 13'($urandom);
                op = 3'($urandom_range(0, 7));
            end
        end
        bus13.i_valid = 1'b0;
        checks++;
        if (got != 40) begin
            errors++;
            $display("[TB] FAIL narrow_count: got %0d expected 40", got);
        end
    endtask

`ifdef PIPELINED_COMPARE_COUNT_EN
    task automatic test_count();
        int  xfers    = 0;
        bit  mid_done = 0;
        bit  sat_done = 0;
        bit  hit;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        cnt_clr     = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        checks++;
        if (match_cnt !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL count_clear_idle: got %h expected 0000", match_cnt);
        end
        for (int cyc = 0; cyc < 71000 && xfers < 70000; cyc++) begin
            @(posedge clk); #1;
            if (xfers == 1000 && !mid_done) begin
                mid_done = 1;
                checks++;
                if (match_cnt !== 16'd1000) begin
                    errors++;
                    $display("[TB] FAIL count_1000: got %0d expected 1000", match_cnt);
                end
            end
            if (xfers == 65535 && !sat_done) begin
                sat_done = 1;
                checks++;
                if (match_cnt !== 16'hFFFF) begin
                    errors++;
                    $display("[TB] FAIL count_65535: got %h expected ffff", match_cnt);
                end
            end
            bus.i0 = 32'd0; bus.i1 = 32'd0; bus.op = 3'd0;
            bus.i_valid = 1'b1;
            bus.o_ready = 1'b1;
            #1;
            if (bus.o_valid && bus.o_ready && bus.o) xfers++;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (xfers != 70000) begin
            errors++;
            $display("[TB] FAIL count_transfers: got %0d expected 70000", xfers);
        end
        repeat (NSTAGE + 2) @(posedge clk);
        #1;
        checks++;
        if (match_cnt !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL count_saturate: got %h expected ffff", match_cnt);
        end
        for (int pass = 0; pass < 2; pass++) begin
            hit = 0;
            @(posedge clk); #1;
            bus.i0 = 32'd3; bus.i1 = 32'd3; bus.op = 3'd0;
            bus.i_valid = 1'b1;
            for (int k = 0; k < 10 && !hit; k++) begin
                @(posedge clk); #1;
                bus.i_valid = 1'b0;
                if (bus.o_valid) begin
                    hit     = 1;
                    cnt_clr = (pass == 0);
                end
            end
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            checks++;
            if (!hit || match_cnt !== 16'(pass)) begin
                errors++;
                $display("[TB] FAIL count_clr_pass%0d: got %h (seen %0d) expected %0d",
                         pass, match_cnt, hit, pass);
            end
        end
    endtask
`endif

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i0        = '0;
        bus.i1        = '0;
        bus.op        = '0;
        bus.o_ready   = 1'b1;
        bus13.i_valid = 1'b0;
        bus13.i0      = '0;
        bus13.i1      = '0;
        bus13.op      = '0;
        bus13.o_ready = 1'b1;
`ifdef PIPELINED_COMPARE_COUNT_EN
        cnt_clr       = 1'b0;
`endif
        test_reset();
        test_latency();
        test_back_to_back();
        test_carry();
        test_stall();
        test_reset_midstream();
        test_narrow_random();
`ifdef PIPELINED_COMPARE_COUNT_EN
        test_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
